// File: rtl/dist_ram_16x8_reader.sv
// Read-side controller for a distributed-RAM byte ring buffer.
// Drives the RAM's asynchronous read address from the read pointer, moves bytes
// into a single output register on a valid/ready stream, and hands the read
// pointer back to the writer for its full check. Also flags writer overruns
// (sticky) and counts bytes accepted downstream.
//
// Ports:
//   clk_i       clock (shared with the RAM write port)
//   rst_i       synchronous active-high reset
//   wptr_i      writer pointer, binary, MSB is the wrap bit
//   rptr_o      reader pointer, binary, MSB is the wrap bit
//   raddr_o     RAM async read address (low bits of rptr_o)
//   ram_data_i  RAM async read data for raddr_o
//   m_data_o    output byte
//   m_valid_o   m_data_o valid
//   m_ready_i   downstream accepts when m_valid_o & m_ready_i
//   flush_i     discard all pending bytes and clear the overrun flag
//   level_o     bytes pending, including the one held in the output register
//   err_o       sticky overrun flag
//   rd_count_o  bytes accepted downstream, wraps
module dist_ram_16x8_reader #(
  parameter int unsigned AddrW = 4,
  parameter int unsigned DataW = 8,
  parameter int unsigned CntW  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [AddrW:0]   wptr_i,
  output logic [AddrW:0]   rptr_o,
  output logic [AddrW-1:0] raddr_o,
  input  logic [DataW-1:0] ram_data_i,
  output logic [DataW-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  input  logic             flush_i,
  output logic [AddrW:0]   level_o,
  output logic             err_o,
  output logic [CntW-1:0]  rd_count_o
);

  // Occupancy of exactly 2**AddrW means full; anything above is an overrun.
  localparam logic [AddrW:0] FullDiff = {1'b1, {AddrW{1'b0}}};

  logic [AddrW:0]   rptr_q, rptr_d;
  logic [DataW-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [AddrW:0] diff;
  logic           empty;
  logic           overrun;
  logic           accept;
  logic           fetch;

  assign diff    = wptr_i - rptr_q;
  assign empty   = (diff == '0);
  assign overrun = (diff > FullDiff);
  assign accept  = valid_q & m_ready_i;
  // Refill the output register whenever it is empty or being drained this cycle.
  assign fetch   = !empty & (!valid_q | m_ready_i);

  always_comb begin
    rptr_d  = rptr_q;
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    if (accept) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (flush_i) begin
      rptr_d  = wptr_i;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end else begin
      if (overrun) begin
        err_d = 1'b1;
      end
      if (fetch) begin
        data_d  = ram_data_i;
        valid_d = 1'b1;
        rptr_d  = rptr_q + 1'b1;
      end else if (accept) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rptr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      rptr_q  <= rptr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rptr_o     = rptr_q;
  assign raddr_o    = rptr_q[AddrW-1:0];
  assign m_data_o   = data_q;
  assign m_valid_o  = valid_q;
  assign err_o      = err_q;
  assign rd_count_o = cnt_q;
  assign level_o    = diff + {{AddrW{1'b0}}, valid_q};

endmodule

// File: tb/tb_dist_ram_16x8_reader.sv
// Directed bench for dist_ram_16x8_reader: reset, single byte, burst,
// backpressure, pointer wrap, overrun with flush, and flush-cycle accept.
module tb_dist_ram_16x8_reader;

  logic        clk;
  logic        rst;
  logic [4:0]  wptr;
  logic [4:0]  rptr;
  logic [3:0]  raddr;
  logic [7:0]  ram_data;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        flush;
  logic [4:0]  level;
  logic        err;
  logic [15:0] rd_count;

  logic [7:0] ram [16];

  int checks;
  int failures;

  assign ram_data = ram[raddr];

  dist_ram_16x8_reader dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wptr_i     (wptr),
    .rptr_o     (rptr),
    .raddr_o    (raddr),
    .ram_data_i (ram_data),
    .m_data_o   (m_data),
    .m_valid_o  (m_valid),
    .m_ready_i  (m_ready),
    .flush_i    (flush),
    .level_o    (level),
    .err_o      (err),
    .rd_count_o (rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wptr = '0;
    rst  = 1'b1;
    tick();
    rst  = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    wptr     = '0;
    m_ready  = 1'b0;
    flush    = 1'b0;
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    #2;

    // 1: reset state
    do_reset();
    check_eq("rst_valid", 32'(m_valid), 32'd0);
    check_eq("rst_data", 32'(m_data), 32'h00);
    check_eq("rst_rptr", 32'(rptr), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_count", 32'(rd_count), 32'd0);

    // 2: single byte
    ram[0]  = 8'hA5;
    m_ready = 1'b1;
    wptr    = 5'd1;
    #1;
    check_eq("one_level_pre", 32'(level), 32'd1);
    tick();
    check_eq("one_valid", 32'(m_valid), 32'd1);
    check_eq("one_data", 32'(m_data), 32'hA5);
    check_eq("one_rptr", 32'(rptr), 32'd1);
    check_eq("one_level", 32'(level), 32'd1);
    tick();
    check_eq("one_valid_after", 32'(m_valid), 32'd0);
    check_eq("one_count", 32'(rd_count), 32'd1);
    check_eq("one_level_after", 32'(level), 32'd0);

    // 3: full burst, no bubbles
    do_reset();
    for (int i = 0; i < 16; i++) ram[i] = 8'(i);
    m_ready = 1'b1;
    wptr    = 5'd16;
    for (int i = 0; i < 16; i++) begin
      tick();
      check_eq($sformatf("burst_valid%0d", i), 32'(m_valid), 32'd1);
      check_eq($sformatf("burst_data%0d", i), 32'(m_data), 32'(i));
    end
    check_eq("burst_rptr", 32'(rptr), 32'd16);
    tick();
    check_eq("burst_valid_end", 32'(m_valid), 32'd0);
    check_eq("burst_level_end", 32'(level), 32'd0);
    check_eq("burst_count", 32'(rd_count), 32'd16);

    // 4: backpressure
    do_reset();
    ram[0]  = 8'h11;
    ram[1]  = 8'h22;
    ram[2]  = 8'h33;
    m_ready = 1'b0;
    wptr    = 5'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq($sformatf("bp_valid%0d", i), 32'(m_valid), 32'd1);
      check_eq($sformatf("bp_data%0d", i), 32'(m_data), 32'h11);
      check_eq($sformatf("bp_rptr%0d", i), 32'(rptr), 32'd1);
      check_eq($sformatf("bp_level%0d", i), 32'(level), 32'd3);
    end
    m_ready = 1'b1;
    tick();
    check_eq("bp_data2", 32'(m_data), 32'h22);
    check_eq("bp_rptr2", 32'(rptr), 32'd2);
    tick();
    check_eq("bp_data3", 32'(m_data), 32'h33);
    check_eq("bp_rptr3", 32'(rptr), 32'd3);
    tick();
    check_eq("bp_valid_end", 32'(m_valid), 32'd0);
    check_eq("bp_count", 32'(rd_count), 32'd3);

    // 5: wrap from rptr=28 across raddr 15->0
    do_reset();
    m_ready = 1'b0;
    wptr    = 5'd28;
    flush   = 1'b1;
    tick();
    flush   = 1'b0;
    check_eq("wrap_rptr_start", 32'(rptr), 32'd28);
    check_eq("wrap_level_start", 32'(level), 32'd0);
    for (int i = 0; i < 16; i++) ram[i] = 8'hC0 + 8'(i);
    wptr    = 5'd4;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq($sformatf("wrap_data%0d", i), 32'(m_data), 32'hC0 + 32'((12 + i) % 16));
      check_eq($sformatf("wrap_rptr%0d", i), 32'(rptr), 32'((29 + i) % 32));
    end
    tick();
    check_eq("wrap_valid_end", 32'(m_valid), 32'd0);
    check_eq("wrap_count", 32'(rd_count), 32'd8);

    // 6: overrun then flush (rptr=4 here)
    m_ready = 1'b0;
    wptr    = 5'd21;
    #1;
    check_eq("ovr_err_pre", 32'(err), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq($sformatf("ovr_err%0d", i), 32'(err), 32'd1);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("flush_err", 32'(err), 32'd0);
    check_eq("flush_valid", 32'(m_valid), 32'd0);
    check_eq("flush_rptr", 32'(rptr), 32'd21);
    check_eq("flush_level", 32'(level), 32'd0);
    check_eq("flush_count", 32'(rd_count), 32'd8);
    tick();
    check_eq("flush_err_stays", 32'(err), 32'd0);

    // Accept in the flush cycle still counts; held byte is dropped.
    ram[5] = 8'h5A;
    wptr   = 5'd22;
    tick();
    check_eq("fa_valid", 32'(m_valid), 32'd1);
    check_eq("fa_data", 32'(m_data), 32'h5A);
    m_ready = 1'b1;
    flush   = 1'b1;
    tick();
    flush   = 1'b0;
    check_eq("fa_count", 32'(rd_count), 32'd9);
    check_eq("fa_valid_after", 32'(m_valid), 32'd0);
    check_eq("fa_rptr", 32'(rptr), 32'd22);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
